// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller blocks:
// light colour codes, the phase timer state encoding and the default clock rate.
package traffic_pkg;

   localparam logic [1:0] RED    = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] GREEN  = 2'b10;

   // System clock cycles per second; also the prescaler divisor.
   localparam int DEFAULT_CLK_HZ = 10000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      FAULT  = 2'd3
   } timer_state_e;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle pulse per second.
// The counter runs 0..CLK_HZ-1 while enabled, holds while disabled, and
// returns to 0 on clear. `wrap` flags the cycle whose edge completes a second.
module sec_prescaler
   import traffic_pkg::*;
#(
   parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
   input  logic clk,
   input  logic clock_reset,
   input  logic enable,
   input  logic clear,
   output logic wrap
);

   localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt;

   assign wrap = enable && !clear && (cnt == LAST);

   // Count cycles within the current second; clear wins over enable.
   always_ff @(posedge clk or posedge clock_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (clock_reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/phase_timer.sv
// Phase countdown timer for the intersection controller.
// Loads a duration in seconds, counts it down on 1 s prescaler wraps, and
// pulses `phase_done` at the end. Supports pause, abort and retrigger.
// Optional watchdog (define PHASE_TIMER_WDOG_EN): too long in IDLE without a
// `load` latches `fault` until reset. Without it, `fault` stays 0 and the
// prescaler is held at 0 while idle.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int CLK_HZ = DEFAULT_CLK_HZ,
   parameter int WDOG_S = 4
) (
   input  logic       clk,
   input  logic       clock_reset,
   input  logic       load,
   input  logic [7:0] load_s,
   input  logic       pause,
   input  logic       abort,
   output logic       busy,
   output logic [7:0] remaining,
   output logic       sec_tick,
   output logic       phase_done,
   output logic       fault
);

   timer_state_e state;
   logic         active;
   logic         psc_en;
   logic         psc_clr;
   logic         wrap;
   logic         wdog_trip;

   assign active = (state == RUN) || (state == PAUSED);

`ifdef PHASE_TIMER_WDOG_EN
   localparam int WW = $clog2(WDOG_S + 1);

   logic [WW-1:0] wdog_cnt;

   // In IDLE the prescaler free-runs to time the watchdog; FAULT freezes it.
   assign psc_clr = (state != FAULT) && (abort || load);
   assign psc_en  = (state == IDLE) || (active && !pause);

   // Count idle seconds since the last load/abort, saturating at WDOG_S.
   always_ff @(posedge clk or posedge clock_reset) begin
      if (clock_reset) begin
         wdog_cnt <= '0;
      end else if (psc_clr) begin
         wdog_cnt <= '0;
      end else if ((state == IDLE) && wrap && (wdog_cnt != WW'(WDOG_S))) begin
         wdog_cnt <= wdog_cnt + 1'b1;
      end
   end

   assign wdog_trip = (state == IDLE) && wrap && (wdog_cnt == WW'(WDOG_S - 1));
`else
   // No watchdog: the prescaler only runs during an unpaused phase.
   assign psc_clr   = abort || load || (state == IDLE);
   assign psc_en    = active && !pause;
   assign wdog_trip = 1'b0;
`endif

   sec_prescaler #(
      .CLK_HZ(CLK_HZ)
   ) u_prescaler (
      .clk         (clk),
      .clock_reset (clock_reset),
      .enable      (psc_en),
      .clear       (psc_clr),
      .wrap        (wrap)
   );

   // Timer FSM with registered outputs; priority abort > load > pause > count.
   always_ff @(posedge clk or posedge clock_reset) begin
      if (clock_reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         remaining  <= 8'd0;
         sec_tick   <= 1'b0;
         phase_done <= 1'b0;
         fault      <= 1'b0;
      end else begin
         sec_tick   <= 1'b0;
         phase_done <= 1'b0;
         if (state != FAULT) begin
            if (abort) begin
               state     <= IDLE;
               busy      <= 1'b0;
               remaining <= 8'd0;
            end else if (load) begin
               if (load_s != 8'd0) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  remaining <= load_s;
               end else begin
                  // Zero-length phase completes immediately.
                  state      <= IDLE;
                  busy       <= 1'b0;
                  remaining  <= 8'd0;
                  phase_done <= 1'b1;
               end
            end else if (active) begin
               state <= pause ? PAUSED : RUN;
               // wrap is only possible while unpaused.
               if (wrap && (remaining != 8'd0)) begin
                  sec_tick  <= 1'b1;
                  remaining <= remaining - 8'd1;
                  if (remaining == 8'd1) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     phase_done <= 1'b1;
                  end
               end
            end else if (wdog_trip) begin
               state     <= FAULT;
               busy      <= 1'b0;
               remaining <= 8'd0;
               fault     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer (CLK_HZ=10, WDOG_S=3).
// Directed scenarios plus randomized stimulus, all compared every cycle
// against a behavioural model of the phase timer. Honours PHASE_TIMER_WDOG_EN.
module tb_phase_timer;

   localparam int CLK_HZ = 10;
   localparam int WDOG_S = 3;
`ifdef PHASE_TIMER_WDOG_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clock_reset;
   logic       load;
   logic [7:0] load_s;
   logic       pause;
   logic       abort;
   logic       busy;
   logic [7:0] remaining;
   logic       sec_tick;
   logic       phase_done;
   logic       fault;

   phase_timer #(
      .CLK_HZ(CLK_HZ),
      .WDOG_S(WDOG_S)
   ) dut (
      .clk         (clk),
      .clock_reset (clock_reset),
      .load        (load),
      .load_s      (load_s),
      .pause       (pause),
      .abort       (abort),
      .busy        (busy),
      .remaining   (remaining),
      .sec_tick    (sec_tick),
      .phase_done  (phase_done),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int edge_n;
   int done_cnt;
   int last_done;
   int tick_q[$];

   // Reference model: seconds left, cycles left in the current second,
   // cycles spent idle, and the expected outputs after the latest edge.
   bit m_busy, m_tick, m_done, m_fault;
   int m_rem, m_cyc, m_idle;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_tick = 0; m_done = 0; m_fault = 0;
      m_rem = 0; m_cyc = CLK_HZ; m_idle = 0;
   endtask

   task automatic model_step(input bit a, input bit l, input int ls, input bit p);
      m_tick = 0;
      m_done = 0;
      if (m_fault) return;
      if (a) begin
         m_busy = 0; m_rem = 0; m_cyc = CLK_HZ; m_idle = 0;
      end else if (l) begin
         m_cyc = CLK_HZ; m_idle = 0;
         if (ls == 0) begin
            m_busy = 0; m_rem = 0; m_done = 1;
         end else begin
            m_busy = 1; m_rem = ls;
         end
      end else if (m_busy) begin
         if (!p) begin
            m_cyc--;
            if (m_cyc == 0) begin
               m_cyc = CLK_HZ;
               m_rem--;
               m_tick = 1;
               if (m_rem == 0) begin
                  m_busy = 0; m_done = 1; m_idle = 0;
               end
            end
         end
      end else if (WDOG_EN) begin
         m_idle++;
         if (m_idle == WDOG_S * CLK_HZ) m_fault = 1;
      end
   endtask

   task automatic compare_all();
      check("busy", 32'(busy), 32'(m_busy));
      check("remaining", 32'(remaining), 32'(m_rem));
      check("sec_tick", 32'(sec_tick), 32'(m_tick));
      check("phase_done", 32'(phase_done), 32'(m_done));
      check("fault", 32'(fault), 32'(m_fault));
   endtask

   // One clock edge with the given inputs; outputs checked 1 time unit later.
   task automatic cycle(input bit a, input bit l, input int ls, input bit p);
      abort = a; load = l; load_s = 8'(ls); pause = p;
      @(posedge clk);
      edge_n++;
      model_step(a, l, ls, p);
      #1;
      compare_all();
      if (phase_done === 1'b1) begin
         done_cnt++;
         last_done = edge_n;
      end
      if (sec_tick === 1'b1) tick_q.push_back(edge_n);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   task automatic start_test();
      edge_n = -1; done_cnt = 0; last_done = -1;
      tick_q.delete();
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic do_reset();
      abort = 0; load = 0; load_s = 0; pause = 0;
      #2 clock_reset = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_remaining", 32'(remaining), 0);
      check("rst_sec_tick", 32'(sec_tick), 0);
      check("rst_phase_done", 32'(phase_done), 0);
      check("rst_fault", 32'(fault), 0);
      model_reset();
      @(posedge clk);
      #3 clock_reset = 1'b0;
      start_test();
   endtask

   initial begin
      clock_reset = 1'b0;
      abort = 0; load = 0; load_s = 0; pause = 0;
      edge_n = -1;
      do_reset();

      // Plain 3 s phase.
      cycle(0, 1, 3, 0);
      check("t1_busy", 32'(busy), 1);
      check("t1_remaining", 32'(remaining), 3);
      idle_cycles(35);
      check("t1_tick_count", tick_q.size(), 3);
      for (int i = 0; i < tick_q.size() && i < 3; i++)
         check("t1_tick_edge", tick_q[i], 10 * (i + 1));
      check("t1_done_count", done_cnt, 1);
      check("t1_done_edge", last_done, 30);

      // 2 s phase with 7 paused cycles from edge 5.
      do_reset();
      cycle(0, 1, 2, 0);
      idle_cycles(4);
      for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1);
      idle_cycles(25);
      check("t2_done_count", done_cnt, 1);
      check("t2_done_edge", last_done, 27);

      // Retrigger a 5 s phase with 1 s at edge 23.
      do_reset();
      cycle(0, 1, 5, 0);
      idle_cycles(22);
      cycle(0, 1, 1, 0);
      idle_cycles(37);
      check("t3_done_count", done_cnt, 1);
      check("t3_done_edge", last_done, 33);

      // Abort a 4 s phase at edge 15.
      do_reset();
      cycle(0, 1, 4, 0);
      idle_cycles(14);
      cycle(1, 0, 0, 0);
      check("t4_remaining", 32'(remaining), 0);
      check("t4_busy", 32'(busy), 0);
      idle_cycles(45);
      check("t4_done_count", done_cnt, 0);

      // Zero-length load, then load together with abort.
      do_reset();
      cycle(0, 1, 0, 0);
      check("t5_done", 32'(phase_done), 1);
      check("t5_busy", 32'(busy), 0);
      cycle(1, 1, 3, 0);
      check("t5_abort_busy", 32'(busy), 0);
      idle_cycles(40);
      check("t5_done_count", done_cnt, 1);

      // Asynchronous reset in the middle of a phase.
      do_reset();
      cycle(0, 1, 5, 0);
      idle_cycles(12);
      do_reset();

`ifdef PHASE_TIMER_WDOG_EN
      // Watchdog: fault after 30 idle cycles, load ignored, reset clears.
      idle_cycles(29);
      check("wd_fault_early", 32'(fault), 0);
      idle_cycles(1);
      check("wd_fault", 32'(fault), 1);
      cycle(0, 1, 3, 0);
      check("wd_load_ignored", 32'(busy), 0);
      check("wd_fault_held", 32'(fault), 1);
      do_reset();
`else
      // No watchdog: long idle never faults.
      idle_cycles(1000);
      check("nowd_fault", 32'(fault), 0);
      do_reset();
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bit a, l, p;
         int ls;
         if ($urandom_range(0, 299) == 0) do_reset();
         a  = ($urandom_range(0, 39) == 0);
         l  = ($urandom_range(0, 24) == 0);
         ls = ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 3));
         p  = (i % 16 < 4) ? ($urandom_range(0, 1) == 1) : 1'b0;
         cycle(a, l, ls, p);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
